// File: rtl/decode_stage.sv
// Registered RV32I decode stage with valid/ready FIFO toward execute.
// Optional macro DECODE_ILLEGAL_TRAP_EN stores and reports an illegal-opcode flag.
module decode_stage #(
  parameter int PC_W      = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [31:0]                in_instr_i,
  input  logic [PC_W-1:0]            in_pc_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_instr_o,
  output logic [PC_W-1:0]            out_pc_o,
  output logic                       RegWrite_o,
  output logic                       MemWrite_o,
  output logic                       Jump_o,
  output logic                       Branch_o,
  output logic                       ALUSrc_o,
  output logic                       Is_U_type_o,
  output logic [1:0]                 ResultSrc_o,
  output logic [1:0]                 ImmSel_o,
  output logic [1:0]                 ALUOp_type_o,
  output logic                       illegal_o,
  output logic [$clog2(BUF_DEPTH):0] count_o
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] RESSRC_ALU = 2'd0;
  localparam logic [1:0] RESSRC_MEM = 2'd1;
  localparam logic [1:0] RESSRC_PC4 = 2'd2;

  localparam logic [1:0] IMM_SEL_I = 2'd0;
  localparam logic [1:0] IMM_SEL_S = 2'd1;
  localparam logic [1:0] IMM_SEL_B = 2'd2;
  localparam logic [1:0] IMM_SEL_J = 2'd3;

  localparam logic [1:0] ALUOP_TYPE_ADD    = 2'd0;
  localparam logic [1:0] ALUOP_TYPE_BRANCH = 2'd1;
  localparam logic [1:0] ALUOP_TYPE_R_I    = 2'd2;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_R_ALU  = 7'b0110011;

  generate
    if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("decode_stage: BUF_DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic [1:0]      imm_sel;
    logic            is_u_type;
    logic [1:0]      alu_op_type;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic            illegal;
`endif
  } entry_t;

  entry_t          mem_q [BUF_DEPTH];
  entry_t          dec;
  entry_t          head;
  logic [PW-1:0]   wptr_q;
  logic [PW-1:0]   rptr_q;
  logic [CW-1:0]   count_q;
  logic [6:0]      op;
  logic            push;
  logic            pop;

  assign op = in_instr_i[6:0];

  always_comb begin
    dec             = '0;
    dec.instr       = in_instr_i;
    dec.pc          = in_pc_i;
    dec.result_src  = RESSRC_ALU;
    dec.imm_sel     = IMM_SEL_I;
    dec.alu_op_type = ALUOP_TYPE_R_I;
    unique case (1'b1)
      (op == OP_LUI) || (op == OP_AUIPC): begin
        dec.reg_write   = 1'b1;
        dec.alu_src     = 1'b1;
        dec.is_u_type   = 1'b1;
        dec.alu_op_type = ALUOP_TYPE_ADD;
      end
      (op == OP_JAL): begin
        dec.reg_write   = 1'b1;
        dec.result_src  = RESSRC_PC4;
        dec.jump        = 1'b1;
        dec.alu_src     = 1'b1;
        dec.imm_sel     = IMM_SEL_J;
        dec.alu_op_type = ALUOP_TYPE_ADD;
      end
      (op == OP_JALR): begin
        dec.reg_write   = 1'b1;
        dec.result_src  = RESSRC_PC4;
        dec.jump        = 1'b1;
        dec.alu_src     = 1'b1;
        dec.alu_op_type = ALUOP_TYPE_ADD;
      end
      (op == OP_BRANCH): begin
        dec.branch      = 1'b1;
        dec.imm_sel     = IMM_SEL_B;
        dec.alu_op_type = ALUOP_TYPE_BRANCH;
      end
      (op == OP_LOAD): begin
        dec.reg_write   = 1'b1;
        dec.result_src  = RESSRC_MEM;
        dec.alu_src     = 1'b1;
        dec.alu_op_type = ALUOP_TYPE_ADD;
      end
      (op == OP_STORE): begin
        dec.mem_write   = 1'b1;
        dec.alu_src     = 1'b1;
        dec.imm_sel     = IMM_SEL_S;
        dec.alu_op_type = ALUOP_TYPE_ADD;
      end
      (op == OP_I_ALU): begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      (op == OP_R_ALU): begin
        dec.reg_write = 1'b1;
      end
      // Unknown opcodes (incl. low bits != 2'b11) become NOPs
      default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        dec.illegal = 1'b1;
`endif
      end
    endcase
  end

  assign in_ready_o  = (count_q < CW'(BUF_DEPTH));
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i && in_ready_o && !flush_i;
  assign pop         = out_valid_o && out_ready_i && !flush_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage is intentionally left unreset
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= dec;
  end

  assign head         = mem_q[rptr_q];
  assign out_instr_o  = head.instr;
  assign out_pc_o     = head.pc;
  assign RegWrite_o   = head.reg_write;
  assign ResultSrc_o  = head.result_src;
  assign MemWrite_o   = head.mem_write;
  assign Jump_o       = head.jump;
  assign Branch_o     = head.branch;
  assign ALUSrc_o     = head.alu_src;
  assign ImmSel_o     = head.imm_sel;
  assign Is_U_type_o  = head.is_u_type;
  assign ALUOp_type_o = head.alu_op_type;
  assign count_o      = count_q;

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign illegal_o = head.illegal;
`else
  assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode, ordering, backpressure, flush, reset.
// Illegal-opcode expectations follow DECODE_ILLEGAL_TRAP_EN.
module tb_decode_stage;

  localparam logic [1:0] ALU = 2'd0, MEM = 2'd1, PC4 = 2'd2;
  localparam logic [1:0] IS = 2'd0, SS = 2'd1, BS = 2'd2, JS = 2'd3;
  localparam logic [1:0] ADD = 2'd0, BRO = 2'd1, RI = 2'd2;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        reg_write, mem_write, jump, branch, alu_src, is_u;
  logic [1:0]  result_src, imm_sel, alu_op;
  logic        illegal;
  logic [1:0]  count;

  int tests;
  int failed;
  logic exp_ill;

  decode_stage #(.PC_W(32), .BUF_DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_instr_i(in_instr), .in_pc_i(in_pc),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_instr_o(out_instr), .out_pc_o(out_pc),
    .RegWrite_o(reg_write), .MemWrite_o(mem_write),
    .Jump_o(jump), .Branch_o(branch),
    .ALUSrc_o(alu_src), .Is_U_type_o(is_u),
    .ResultSrc_o(result_src), .ImmSel_o(imm_sel),
    .ALUOp_type_o(alu_op), .illegal_o(illegal),
    .count_o(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins,
                       input logic [31:0] pc);
    in_valid = v;
    in_instr = ins;
    in_pc    = pc;
  endtask

  initial begin
    tests = 0;
    failed = 0;
`ifdef DECODE_ILLEGAL_TRAP_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // ADDI
    drive(1'b1, 32'h00500093, 32'h100);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_regwrite", 32'(reg_write), 32'd1);
    chk("addi_alusrc", 32'(alu_src), 32'd1);
    chk("addi_immsel", 32'(imm_sel), 32'(IS));
    chk("addi_aluop", 32'(alu_op), 32'(RI));
    chk("addi_pc", out_pc, 32'h100);
    chk("addi_memwrite", 32'(mem_write), 32'd0);
    chk("addi_illegal", 32'(illegal), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("addi_drained", 32'(count), 32'd0);

    // LW, SW, JAL back-to-back
    drive(1'b1, 32'h0000A103, 32'h104);
    tick();
    chk("lw_ressrc", 32'(result_src), 32'(MEM));
    chk("lw_instr", out_instr, 32'h0000A103);
    chk("lw_count", 32'(count), 32'd1);
    drive(1'b1, 32'h0020A023, 32'h108);
    tick();
    chk("sw_memwrite", 32'(mem_write), 32'd1);
    chk("sw_immsel", 32'(imm_sel), 32'(SS));
    chk("sw_regwrite", 32'(reg_write), 32'd0);
    chk("sw_count", 32'(count), 32'd1);
    drive(1'b1, 32'h000000EF, 32'h10C);
    tick();
    chk("jal_jump", 32'(jump), 32'd1);
    chk("jal_ressrc", 32'(result_src), 32'(PC4));
    chk("jal_immsel", 32'(imm_sel), 32'(JS));
    chk("jal_pc", out_pc, 32'h10C);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("stream_empty", 32'(out_valid), 32'd0);

    // Backpressure and pointer wrap
    out_ready = 1'b0;
    drive(1'b1, 32'h00100113, 32'h200);
    tick();
    chk("bp_count1", 32'(count), 32'd1);
    chk("bp_ready1", 32'(in_ready), 32'd1);
    drive(1'b1, 32'h00200193, 32'h204);
    tick();
    chk("bp_count2", 32'(count), 32'd2);
    chk("bp_ready_low", 32'(in_ready), 32'd0);
    drive(1'b1, 32'h00300213, 32'h208);
    tick();
    chk("bp_full_hold", 32'(count), 32'd2);
    chk("bp_head0", out_pc, 32'h200);
    out_ready = 1'b1;
    tick();
    chk("bp_pop_full", 32'(count), 32'd1);
    chk("bp_head1", out_pc, 32'h204);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    tick();
    chk("bp_wrap_count", 32'(count), 32'd1);
    chk("bp_head2_pc", out_pc, 32'h208);
    chk("bp_head2_instr", out_instr, 32'h00300213);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("bp_drained", 32'(count), 32'd0);

    // Flush with two entries buffered
    out_ready = 1'b0;
    drive(1'b1, 32'h00000013, 32'h300);
    tick();
    drive(1'b1, 32'h00000013, 32'h304);
    tick();
    chk("fl_pre_count", 32'(count), 32'd2);
    flush = 1'b1;
    drive(1'b1, 32'h00800093, 32'h308);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_valid", 32'(out_valid), 32'd0);
    tick();
    chk("fl_dropped", 32'(out_valid), 32'd0);

    // Flush drops a fresh input while not full
    drive(1'b1, 32'h00000013, 32'h310);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'h00900093, 32'h314);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl1_count", 32'(count), 32'd0);
    tick();
    chk("fl1_dropped", 32'(out_valid), 32'd0);

    // Unrecognised opcode, then LUI, BEQ, JALR
    drive(1'b1, 32'h0000007F, 32'h400);
    tick();
    chk("ill_valid", 32'(out_valid), 32'd1);
    chk("ill_flag", 32'(illegal), 32'(exp_ill));
    chk("ill_enables",
        32'({reg_write, mem_write, jump, branch, alu_src, is_u}), 32'd0);
    chk("ill_ressrc", 32'(result_src), 32'(ALU));
    chk("ill_immsel", 32'(imm_sel), 32'(IS));
    chk("ill_aluop", 32'(alu_op), 32'(RI));
    out_ready = 1'b1;
    drive(1'b1, 32'h123450B7, 32'h404);
    tick();
    chk("lui_isu", 32'(is_u), 32'd1);
    chk("lui_alusrc", 32'(alu_src), 32'd1);
    chk("lui_aluop", 32'(alu_op), 32'(ADD));
    chk("lui_illegal", 32'(illegal), 32'd0);
    drive(1'b1, 32'h00208463, 32'h408);
    tick();
    chk("beq_branch", 32'(branch), 32'd1);
    chk("beq_regwrite", 32'(reg_write), 32'd0);
    chk("beq_immsel", 32'(imm_sel), 32'(BS));
    chk("beq_aluop", 32'(alu_op), 32'(BRO));
    drive(1'b1, 32'h000080E7, 32'h40C);
    tick();
    chk("jalr_jump", 32'(jump), 32'd1);
    chk("jalr_ressrc", 32'(result_src), 32'(PC4));
    chk("jalr_immsel", 32'(imm_sel), 32'(IS));
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("dec_drained", 32'(count), 32'd0);

    // Reset while full
    out_ready = 1'b0;
    drive(1'b1, 32'h00000013, 32'h500);
    tick();
    drive(1'b1, 32'h00000013, 32'h504);
    tick();
    chk("rf_full", 32'(count), 32'd2);
    rst_n = 1'b0;
    drive(1'b1, 32'h00000013, 32'h508);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    chk("rf_count", 32'(count), 32'd0);
    chk("rf_in_ready", 32'(in_ready), 32'd1);
    chk("rf_out_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, flow-controlled instruction decode stage for the RV32I core. Accepts fetched instructions with PC over a valid/ready handshake, decodes the 7-bit opcode into the standard control bundle, and buffers decoded entries in a parametrised FIFO toward execute. Sits between fetch and execute; replaces the purely combinational opcode decode in the single-cycle datapath. Supports flush and optional illegal-opcode flagging.

## Interface
- `PC_W`, default 32: width of the PC carried with each instruction.
- `BUF_DEPTH`, default 2: FIFO entries. Must be a power of two and at least 2; elaboration error otherwise.
- `clk_i` input 1: clock. All state updates on rising edge.
- `rst_ni` input 1: reset, synchronous, active-low.
- `flush_i` input 1: discard all buffered entries and the current input.
- `in_valid_i` input 1: fetch presents an instruction.
- `in_ready_o` output 1: stage can accept an instruction.
- `in_instr_i` input 32: instruction word.
- `in_pc_i` input `PC_W`: PC of the instruction.
- `out_valid_o` output 1: head entry valid.
- `out_ready_i` input 1: execute consumes head entry.
- `out_instr_o` output 32; `out_pc_o` output `PC_W`: carried fields of head entry.
- `RegWrite_o`, `MemWrite_o`, `Jump_o`, `Branch_o`, `ALUSrc_o`, `Is_U_type_o` output 1 each: control bits of head entry.
- `ResultSrc_o`, `ImmSel_o`, `ALUOp_type_o` output 2 each: encoded with `RESSRC_*`, `IMM_SEL_*`, `ALUOP_TYPE_*` from `common/defines.svh`.
- `illegal_o` output 1: head entry has an unrecognised opcode.
- `count_o` output `$clog2(BUF_DEPTH)+1`: current occupancy.

## Operation
- Decode is combinational on `in_instr_i[6:0]`. The decoded bundle, instruction, and PC are written into the FIFO on push.
- Opcode mapping, as `RegWrite`, `ResultSrc`, `MemWrite`, `Jump`, `Branch`, `ALUSrc`, `ImmSel`, `Is_U_type`, `ALUOp_type`:
  - LUI and AUIPC: 1, ALU, 0, 0, 0, 1, I, 1, ADD.
  - JAL: 1, PC4, 0, 1, 0, 1, J, 0, ADD.
  - JALR: 1, PC4, 0, 1, 0, 1, I, 0, ADD.
  - BRANCH: 0, ALU, 0, 0, 1, 0, B, 0, BRANCH.
  - LOAD: 1, MEM, 0, 0, 0, 1, I, 0, ADD.
  - STORE: 0, ALU, 1, 0, 0, 1, S, 0, ADD.
  - I_ALU: 1, ALU, 0, 0, 0, 1, I, 0, R_I.
  - R_ALU: 1, ALU, 0, 0, 0, 0, I, 0, R_I.
  - Any other opcode is a NOP bundle: all bits 0, ALU, I, R_I.
- Push condition: `in_valid_i && in_ready_o && !flush_i`.
- Pop condition: `out_valid_o && out_ready_i && !flush_i`.
- `in_ready_o = (count < BUF_DEPTH)`. It depends only on registered state, with no combinational path from `out_ready_i`.
- `out_valid_o = (count != 0)`. All head outputs come straight from FIFO storage at the read pointer.
- Pointers are `$clog2(BUF_DEPTH)` bits and wrap naturally modulo `BUF_DEPTH`. `count` is updated as +1, −1, or unchanged.
- Full with a pop in the same cycle: no push, since `in_ready_o` is 0. Count decrements.
- Empty with a push: the entry appears next cycle. There is no bypass.
- Push and pop together when neither full nor empty: count is unchanged and both pointers advance.
- `flush_i`: next cycle count=0 and both pointers are 0. The input in the flush cycle is dropped even if `in_valid_i` is 1. Flush wins over push and pop.
- Handshake rule: once `out_valid_o` is 1, the head contents stay stable until popped or flushed.

## Timing
- Latency: an instruction accepted in cycle N is visible at the output in cycle N+1.
- Throughput: 1 instruction per cycle when `out_ready_i` is held at 1.
- Reset, while `rst_ni`=0 at an edge: count=0, pointers=0. Consequently `out_valid_o`=0, `in_ready_o`=1, and `count_o`=0.
- Storage contents are not reset. Head data outputs are don't-care while `out_valid_o`=0, and the bench must not check them.
- Reset asserted mid-operation discards all entries exactly like flush, and overrides flush.

## Configuration
- `DECODE_ILLEGAL_TRAP_EN` defined:
  - Unrecognised opcodes set the stored `illegal` bit to 1, with the NOP bundle.
  - Opcodes whose low two bits are not `2'b11` are also flagged as illegal.
- `DECODE_ILLEGAL_TRAP_EN` undefined:
  - The `illegal` bit is not stored and `illegal_o` is tied to 0.
  - Unrecognised opcodes flow as NOPs.

## Test plan
- Reset, then push ADDI `0x00500093` at PC `0x100`. Next cycle: `out_valid_o`=1, `RegWrite_o`=1, `ALUSrc_o`=1, `ImmSel_o`=I, `ALUOp_type_o`=R_I, `out_pc_o`=`0x100`.
- Push LW `0x0000A103`, SW `0x0020A023`, and JAL `0x000000EF` back-to-back with `out_ready_i`=1. Outputs appear in order one cycle later:
  - `ResultSrc_o`=MEM.
  - `MemWrite_o`=1 with `ImmSel_o`=S.
  - `Jump_o`=1 with `ResultSrc_o`=PC4.
- Hold `out_ready_i`=0 and push 3 instructions with `BUF_DEPTH`=2. `in_ready_o` falls after 2 accepts and `count_o`=2. Then raise `out_ready_i`: the first two instructions drain in order, the third is then accepted, and the pointers wrap correctly.
- With 2 entries buffered, assert `flush_i` together with `in_valid_i`. Next cycle: `count_o`=0, `out_valid_o`=0, and the flushed input is never output.
- Push `0x0000007F`. With `DECODE_ILLEGAL_TRAP_EN` defined: `illegal_o`=1 and all enables are 0. Without it: `illegal_o`=0 and the NOP bundle is output.
- Pull `rst_ni` low while the FIFO is full and `flush_i`=0. Next cycle: `count_o`=0, `in_ready_o`=1, `out_valid_o`=0.
